// File: rtl/poly1305_mac_p_if.sv
// Block-load handshake between the message sequencer and the Poly1305 core.
// The sequencer drives key, message and framing; the core returns tag and status.
interface poly1305_mac_p_if;
  logic [127:0] r;
  logic [127:0] s;
  logic [127:0] m;
  logic [4:0]   len;
  logic         ld;
  logic         first;
  logic         last;
  logic [127:0] p;
  logic         rdy;
  logic         tag_vld;
  logic         err;

  modport master (
    output r, s, m, len, ld, first, last,
    input  p, rdy, tag_vld, err
  );

  modport slave (
    input  r, s, m, len, ld, first, last,
    output p, rdy, tag_vld, err
  );
endinterface

// File: rtl/poly1305_mac_p.sv
// Poly1305 one-time authenticator with a digit-serial multiplier of width DW.
// One block is absorbed per ld: h := (h + n) * r mod 2^130-5, then tag = h + s.
module poly1305_mac_p #(
  parameter int DW    = 32,
  parameter bit CLAMP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  poly1305_mac_p_if.slave  bus
);
  localparam int NDIG = 128 / DW;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int TW   = 132 + DW;
  localparam logic [130:0] PRIME      = (131'd1 << 130) - 131'd5;
  localparam logic [127:0] CLAMP_MASK = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

  typedef enum logic [1:0] {IDLE, MUL, RED, FIN} state_t;

  state_t         state_q, state_d;
  logic [129:0]   h_q, h_d;
  logic [127:0]   r_q, r_d;
  logic [127:0]   s_q, s_d;
  logic [130:0]   a_q, a_d;
  logic [130:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic [127:0]   p_q, p_d;
  logic           tagVld_q, tagVld_d;
  logic           err_q, err_d;

  logic           lenOk;
  logic [128:0]   lenBit;
  logic [128:0]   blockN;
  logic [129:0]   hBase;
  logic [DW-1:0]  rDig [NDIG];
  logic [DW-1:0]  digit;
  logic [130+DW:0] part;
  logic [TW-1:0]  prod;
  logic [DW+1:0]  hi;
  logic [DW+4:0]  fold5;
  logic [130:0]   folded;
  logic [130:0]   red1, red2;

  assign lenOk = (bus.len != 5'd0) && (bus.len <= 5'd16);

  // Append the 0x01 pad byte just above the valid bytes and drop everything past it.
  always_comb begin
    lenBit = 129'd1 << {bus.len, 3'b000};
    blockN = ({1'b0, bus.m} & (lenBit - 129'd1)) | lenBit;
  end

  // Horner step: shift acc by one digit, add a*digit, fold bits >= 130 back as *5.
  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      rDig[i] = r_q[i*DW +: DW];
    end
    digit  = rDig[cnt_q];
    part   = {{DW{1'b0}}, a_q} * {{131{1'b0}}, digit};
    prod   = {1'b0, acc_q, {DW{1'b0}}} + {1'b0, part};
    hi     = prod[TW-1:130];
    fold5  = {1'b0, hi, 2'b00} + {3'b000, hi};
    folded = {1'b0, prod[129:0]} + {{(126-DW){1'b0}}, fold5};
    red1   = (acc_q >= PRIME) ? acc_q - PRIME : acc_q;
    red2   = (red1 >= PRIME) ? red1 - PRIME : red1;
  end

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    r_d      = r_q;
    s_d      = s_q;
    a_d      = a_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    p_d      = p_q;
    tagVld_d = 1'b0;
    err_d    = 1'b0;
    hBase    = h_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ld) begin
          if (!lenOk) begin
            err_d = 1'b1;
          end else begin
            if (bus.first) begin
              hBase = '0;
              h_d   = '0;
              r_d   = CLAMP ? (bus.r & CLAMP_MASK) : bus.r;
              s_d   = bus.s;
            end
            a_d     = {1'b0, hBase} + {2'b00, blockN};
            acc_d   = '0;
            cnt_d   = CW'(NDIG - 1);
            last_d  = bus.last;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        acc_d = folded;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = RED;
        end
      end
      RED: begin
        h_d     = red2[129:0];
        state_d = last_q ? FIN : IDLE;
      end
      FIN: begin
        p_d      = h_q[127:0] + s_q;
        tagVld_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      h_q      <= '0;
      r_q      <= '0;
      s_q      <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      p_q      <= '0;
      tagVld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      r_q      <= r_d;
      s_q      <= s_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      p_q      <= p_d;
      tagVld_q <= tagVld_d;
      err_q    <= err_d;
    end
  end

  assign bus.p       = p_q;
  assign bus.rdy     = (state_q == IDLE);
  assign bus.tag_vld = tagVld_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_poly1305_mac_p.sv
// Directed bench for poly1305_mac_p: four cores (DW = 8/16/32/64) share data inputs,
// each has its own ld; RFC 8439 vector, key edge cases, illegal lengths and reset.
module tb_poly1305_mac_p;
  localparam logic [127:0] R_RFC   = 128'ha806d542fe52447f336d555778bed685;
  localparam logic [127:0] S_RFC   = 128'h1bf54941aff6bf4afdb20dfb8a800301;
  localparam logic [127:0] M1      = 128'h6f4620636968706172676f7470797243;
  localparam logic [127:0] M2      = 128'h6f7247206863726165736552206d7572;
  localparam logic [127:0] M3      = 128'h00000000000000000000000000007075;
  localparam logic [127:0] TAG_RFC = 128'ha927010caf8b2bc2c6365130c11d06a8;
  localparam logic [127:0] S_ONES  = 128'h11111111111111111111111111111111;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] rIn, sIn, mIn;
  logic [4:0]   lenIn;
  logic         firstIn, lastIn;
  logic         ldV   [4];
  logic         rdyV  [4];
  logic         tagV  [4];
  logic         errV  [4];
  logic [127:0] pV    [4];
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gCore
    poly1305_mac_p_if bus ();
    assign bus.r     = rIn;
    assign bus.s     = sIn;
    assign bus.m     = mIn;
    assign bus.len   = lenIn;
    assign bus.first = firstIn;
    assign bus.last  = lastIn;
    assign bus.ld    = ldV[g];
    assign rdyV[g]   = bus.rdy;
    assign tagV[g]   = bus.tag_vld;
    assign errV[g]   = bus.err;
    assign pV[g]     = bus.p;
    poly1305_mac_p #(.DW(8 << g), .CLAMP(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Called at a negedge; returns at the negedge where rdy is back, counting tag pulses.
  task automatic sendBlock(input int idx, input logic [127:0] mv, input logic [4:0] lv,
                           input logic f, input logic l, input bit poke,
                           output int lat, output int tags);
    mIn = mv; lenIn = lv; firstIn = f; lastIn = l; ldV[idx] = 1'b1;
    @(posedge clk);
    lat  = 1;
    tags = 0;
    @(negedge clk);
    ldV[idx] = 1'b0;
    mIn = '1; lenIn = 5'd0;
    while (rdyV[idx] !== 1'b1 && lat < 100) begin
      if (tagV[idx] === 1'b1) tags++;
      if (poke && lat == 2) begin
        mIn = 128'hdeadbeefcafef00d0123456789abcdef;
        lenIn = 5'd16; firstIn = 1'b1; lastIn = 1'b1; ldV[idx] = 1'b1;
      end
      if (poke && lat == 3) ldV[idx] = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (tagV[idx] === 1'b1) tags++;
  endtask

  task automatic runRfc(input int idx, input bit poke, output int lat1, output int lat2,
                        output int lat3, output int tags);
    int t;
    rIn = R_RFC; sIn = S_RFC;
    sendBlock(idx, M1, 5'd16, 1'b1, 1'b0, poke, lat1, t);
    tags = t;
    rIn = '0; sIn = '0;
    sendBlock(idx, M2, 5'd16, 1'b0, 1'b0, 1'b0, lat2, t);
    tags += t;
    sendBlock(idx, M3, 5'd2, 1'b0, 1'b1, 1'b0, lat3, t);
    tags += t;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) ldV[i] = 1'b0;
    rIn = '0; sIn = '0; mIn = '0; lenIn = 5'd0; firstIn = 1'b0; lastIn = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests++; if (rdyV[i] !== 1'b1) begin fails++; $display("[TB] FAIL reset_rdy core%0d got %b want 1", i, rdyV[i]); end
      tests++; if (pV[i] !== 128'd0) begin fails++; $display("[TB] FAIL reset_p core%0d got %h want 0", i, pV[i]); end
      tests++; if (tagV[i] !== 1'b0) begin fails++; $display("[TB] FAIL reset_tag core%0d got %b want 0", i, tagV[i]); end
      tests++; if (errV[i] !== 1'b0) begin fails++; $display("[TB] FAIL reset_err core%0d got %b want 0", i, errV[i]); end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rfc_widths();
    int l1, l2, l3, tg, ndig;
    for (int i = 0; i < 4; i++) begin
      ndig = 16 >> i;
      runRfc(i, 1'b0, l1, l2, l3, tg);
      tests++; if (pV[i] !== TAG_RFC) begin fails++; $display("[TB] FAIL rfc_tag dw=%0d got %h want %h", 8 << i, pV[i], TAG_RFC); end
      tests++; if (l1 != ndig + 2) begin fails++; $display("[TB] FAIL rfc_lat1 dw=%0d got %0d want %0d", 8 << i, l1, ndig + 2); end
      tests++; if (l2 != ndig + 2) begin fails++; $display("[TB] FAIL rfc_lat2 dw=%0d got %0d want %0d", 8 << i, l2, ndig + 2); end
      tests++; if (l3 != ndig + 3) begin fails++; $display("[TB] FAIL rfc_lat3 dw=%0d got %0d want %0d", 8 << i, l3, ndig + 3); end
      tests++; if (tg != 1) begin fails++; $display("[TB] FAIL rfc_tagcnt dw=%0d got %0d want 1", 8 << i, tg); end
      @(negedge clk);
      tests++; if (tagV[i] !== 1'b0) begin fails++; $display("[TB] FAIL rfc_tagpulse dw=%0d got %b want 0", 8 << i, tagV[i]); end
    end
  endtask

  task automatic test_zero_r();
    int lat, tg;
    rIn = '0; sIn = S_ONES;
    sendBlock(2, 128'h0123456789abcdeffedcba9876543210, 5'd16, 1'b1, 1'b1, 1'b0, lat, tg);
    tests++; if (pV[2] !== S_ONES) begin fails++; $display("[TB] FAIL zero_r_tag got %h want %h", pV[2], S_ONES); end
    tests++; if (lat != 7) begin fails++; $display("[TB] FAIL zero_r_lat got %0d want 7", lat); end
    tests++; if (tg != 1) begin fails++; $display("[TB] FAIL zero_r_tagcnt got %0d want 1", tg); end
  endtask

  task automatic test_illegal_len();
    logic [4:0] badLen [2];
    int l1, l2, l3, tg;
    badLen[0] = 5'd0;
    badLen[1] = 5'd17;
    for (int k = 0; k < 2; k++) begin
      rIn = R_RFC; sIn = S_RFC; mIn = M1; lenIn = badLen[k];
      firstIn = 1'b1; lastIn = 1'b1; ldV[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ldV[2] = 1'b0;
      tests++; if (errV[2] !== 1'b1) begin fails++; $display("[TB] FAIL illegal_err len=%0d got %b want 1", badLen[k], errV[2]); end
      tests++; if (rdyV[2] !== 1'b1) begin fails++; $display("[TB] FAIL illegal_rdy len=%0d got %b want 1", badLen[k], rdyV[2]); end
      @(negedge clk);
      tests++; if (errV[2] !== 1'b0) begin fails++; $display("[TB] FAIL illegal_errpulse len=%0d got %b want 0", badLen[k], errV[2]); end
    end
    runRfc(2, 1'b0, l1, l2, l3, tg);
    tests++; if (pV[2] !== TAG_RFC) begin fails++; $display("[TB] FAIL illegal_then_tag got %h want %h", pV[2], TAG_RFC); end
  endtask

  task automatic test_ignore_busy();
    int l1, l2, l3, tg;
    runRfc(2, 1'b1, l1, l2, l3, tg);
    tests++; if (pV[2] !== TAG_RFC) begin fails++; $display("[TB] FAIL busy_tag got %h want %h", pV[2], TAG_RFC); end
    tests++; if (l1 != 6) begin fails++; $display("[TB] FAIL busy_lat1 got %0d want 6", l1); end
    tests++; if (tg != 1) begin fails++; $display("[TB] FAIL busy_tagcnt got %0d want 1", tg); end
  endtask

  task automatic test_reset_mid();
    int lat, tg, l1, l2, l3;
    rIn = R_RFC; sIn = S_RFC;
    sendBlock(2, M1, 5'd16, 1'b1, 1'b0, 1'b0, lat, tg);
    mIn = M2; lenIn = 5'd16; firstIn = 1'b0; lastIn = 1'b0; ldV[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ldV[2] = 1'b0;
    @(negedge clk);
    tests++; if (rdyV[2] !== 1'b0) begin fails++; $display("[TB] FAIL midmul_busy got %b want 0", rdyV[2]); end
    reset = 1'b1;
    #1;
    tests++; if (rdyV[2] !== 1'b1) begin fails++; $display("[TB] FAIL midreset_rdy got %b want 1", rdyV[2]); end
    tests++; if (pV[2] !== 128'd0) begin fails++; $display("[TB] FAIL midreset_p got %h want 0", pV[2]); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    runRfc(2, 1'b0, l1, l2, l3, tg);
    tests++; if (pV[2] !== TAG_RFC) begin fails++; $display("[TB] FAIL after_reset_tag got %h want %h", pV[2], TAG_RFC); end
    tests++; if (tg != 1) begin fails++; $display("[TB] FAIL after_reset_tagcnt got %0d want 1", tg); end
  endtask

  initial begin
    test_reset();
    test_rfc_widths();
    test_zero_r();
    test_illegal_len();
    test_ignore_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
